// File: rtl/reg_file_param.sv
// Parametrised CPU register file: two combinational reads, one synchronous write,
// hardware clear sweep after reset/ClearReq. Optional same-cycle forwarding: REGFILE_BYPASS_EN.
module reg_file_param #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int ZERO_REG0 = 0
) (
   input  logic              Clock,
   input  logic              ResetN,
   input  logic [ADDR_W-1:0] RS,
   input  logic [ADDR_W-1:0] RT,
   input  logic [ADDR_W-1:0] RD,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   input  logic              ClearReq,
   output logic [DATA_W-1:0] ReadRS,
   output logic [DATA_W-1:0] ReadRT,
   output logic              Ready,
   output logic              WriteDropped
);

   localparam int                NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t            state, stateNext;
   logic [ADDR_W-1:0] clearIdx, clearIdxNext;
   logic              writeDroppedNext;
   logic              sweepWe, userWe;
   logic [DATA_W-1:0] registers [NUM_REGS];

   function automatic logic isHardZero(input logic [ADDR_W-1:0] idx);
      return (ZERO_REG0 != 0) && (idx == '0);
   endfunction

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state        <= CLEAR;
         clearIdx     <= '0;
         WriteDropped <= 1'b0;
      end else begin
         state        <= stateNext;
         clearIdx     <= clearIdxNext;
         WriteDropped <= writeDroppedNext;
      end
   end

   always_comb begin
      stateNext        = state;
      clearIdxNext     = clearIdx;
      writeDroppedNext = 1'b0;
      sweepWe          = 1'b0;
      userWe           = 1'b0;
      case (state)
         CLEAR: begin
            sweepWe          = 1'b1;
            writeDroppedNext = RegWrite;
            if (clearIdx == LAST_IDX) begin
               stateNext    = RUN;
               clearIdxNext = '0;
            end else begin
               clearIdxNext = clearIdx + ADDR_W'(1);
            end
         end
         RUN: begin
            // A write coinciding with ClearReq still lands; the sweep wipes it afterwards.
            userWe = RegWrite && !isHardZero(RD);
            if (ClearReq) begin
               stateNext    = CLEAR;
               clearIdxNext = '0;
            end
         end
         default: stateNext = CLEAR;
      endcase
   end

   assign Ready = (state == RUN);

   // Array contents carry no reset; the sweep is what zeroes them.
   always_ff @(posedge Clock) begin
      if (ResetN) begin
         if (sweepWe)
            registers[clearIdx] <= '0;
         else if (userWe)
            registers[RD] <= WriteData;
      end
   end

   always_comb begin
      ReadRS = registers[RS];
      ReadRT = registers[RT];
`ifdef REGFILE_BYPASS_EN
      if (userWe && (RD == RS)) ReadRS = WriteData;
      if (userWe && (RD == RT)) ReadRT = WriteData;
`endif
      if ((state != RUN) || isHardZero(RS)) ReadRS = '0;
      if ((state != RUN) || isHardZero(RT)) ReadRT = '0;
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default 8x16 instance and a 16-entry hardwired-zero instance.
module tb_reg_file_param;

   logic        Clock = 1'b0;
   logic        ResetN, RegWrite, ClearReq;
   logic [3:0]  rs, rt, rd;
   logic [15:0] WriteData;
   logic [15:0] rsA, rtA, rsB, rtB;
   logic        readyA, readyB, dropA, dropB;

   int errors = 0;
   int checks = 0;

   logic [15:0] mA [8];
   logic [15:0] mB [16];
   int          sweepA, sweepB;
   logic        expDropA, expDropB;

   always #5 Clock = ~Clock;

   reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG0(0)) dutA (
      .Clock(Clock), .ResetN(ResetN), .RS(rs[2:0]), .RT(rt[2:0]), .RD(rd[2:0]),
      .WriteData(WriteData), .RegWrite(RegWrite), .ClearReq(ClearReq),
      .ReadRS(rsA), .ReadRT(rtA), .Ready(readyA), .WriteDropped(dropA));

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG0(1)) dutB (
      .Clock(Clock), .ResetN(ResetN), .RS(rs), .RT(rt), .RD(rd),
      .WriteData(WriteData), .RegWrite(RegWrite), .ClearReq(ClearReq),
      .ReadRS(rsB), .ReadRT(rtB), .Ready(readyB), .WriteDropped(dropB));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Any sweep leaves the file all-zero and blocks reads/writes until done, so the
   // reference simply zeroes everything when a sweep starts and counts edges down.
   function automatic logic [15:0] expRead(input bit isB, input logic [3:0] idx);
      if (isB) begin
         if (sweepB > 0 || idx == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
         if (RegWrite && rd == idx) return WriteData;
`endif
         return mB[idx];
      end else begin
         if (sweepA > 0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
         if (RegWrite && rd[2:0] == idx[2:0]) return WriteData;
`endif
         return mA[idx[2:0]];
      end
   endfunction

   task automatic modelEdge();
      if (!ResetN) begin
         foreach (mA[i]) mA[i] = 16'h0000;
         foreach (mB[i]) mB[i] = 16'h0000;
         sweepA = 8; sweepB = 16; expDropA = 1'b0; expDropB = 1'b0;
      end else begin
         if (sweepA > 0) begin
            sweepA--; expDropA = RegWrite;
         end else begin
            expDropA = 1'b0;
            if (RegWrite) mA[rd[2:0]] = WriteData;
            if (ClearReq) begin
               foreach (mA[i]) mA[i] = 16'h0000;
               sweepA = 8;
            end
         end
         if (sweepB > 0) begin
            sweepB--; expDropB = RegWrite;
         end else begin
            expDropB = 1'b0;
            if (RegWrite && rd != 4'd0) mB[rd] = WriteData;
            if (ClearReq) begin
               foreach (mB[i]) mB[i] = 16'h0000;
               sweepB = 16;
            end
         end
      end
   endtask

   // Inputs are set at the falling edge; outputs are checked 1ns later, then the edge is modelled.
   task automatic cyc(input bit doCheck);
      #1;
      if (doCheck) begin
         chk("A.ReadRS", rsA, expRead(1'b0, rs));
         chk("A.ReadRT", rtA, expRead(1'b0, rt));
         chk("A.Ready", {15'b0, readyA}, {15'b0, sweepA == 0});
         chk("A.WriteDropped", {15'b0, dropA}, {15'b0, expDropA});
         chk("B.ReadRS", rsB, expRead(1'b1, rs));
         chk("B.ReadRT", rtB, expRead(1'b1, rt));
         chk("B.Ready", {15'b0, readyB}, {15'b0, sweepB == 0});
         chk("B.WriteDropped", {15'b0, dropB}, {15'b0, expDropB});
      end
      @(posedge Clock);
      modelEdge();
      @(negedge Clock);
   endtask

   initial begin
      ResetN = 1'b0; RegWrite = 1'b0; ClearReq = 1'b0;
      rs = 4'd0; rt = 4'd0; rd = 4'd0; WriteData = 16'h0000;
      sweepA = 0; sweepB = 0; expDropA = 1'b0; expDropB = 1'b0;
      @(negedge Clock);

      // Reset held two cycles, then release and watch both sweeps complete.
      cyc(1'b0);
      cyc(1'b1);
      ResetN = 1'b1;
      repeat (20) cyc(1'b1);
      for (int i = 0; i < 16; i++) begin
         rs = 4'(i); rt = 4'(15 - i);
         cyc(1'b1);
      end

      // Basic write/read and RS==RT.
      RegWrite = 1'b1; rd = 4'd3; WriteData = 16'hBEEF; cyc(1'b1);
      rd = 4'd5; WriteData = 16'h1234; cyc(1'b1);
      RegWrite = 1'b0; rs = 4'd3; rt = 4'd5; cyc(1'b1);
      rt = 4'd3; cyc(1'b1);

      // Read-during-write.
      RegWrite = 1'b1; rd = 4'd2; WriteData = 16'h0001; cyc(1'b1);
      WriteData = 16'hA5A5; rs = 4'd2; rt = 4'd2; cyc(1'b1);
      RegWrite = 1'b0; cyc(1'b1);

      // Fill, then ClearReq with a simultaneous write, a dropped write and an ignored ClearReq.
      RegWrite = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd = 4'(i); WriteData = 16'((i + 1) * 16'h1111);
         cyc(1'b1);
      end
      RegWrite = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rs = 4'(i); rt = 4'(7 - i);
         cyc(1'b1);
      end
      RegWrite = 1'b1; rd = 4'd1; WriteData = 16'h9999; ClearReq = 1'b1; rs = 4'd1;
      cyc(1'b1);
      RegWrite = 1'b0; ClearReq = 1'b0; cyc(1'b1);
      RegWrite = 1'b1; rd = 4'd4; WriteData = 16'h7777; rs = 4'd4; cyc(1'b1);
      RegWrite = 1'b0; ClearReq = 1'b1; cyc(1'b1);
      ClearReq = 1'b0;
      repeat (18) cyc(1'b1);
      for (int i = 0; i < 16; i++) begin
         rs = 4'(i); rt = 4'(15 - i);
         cyc(1'b1);
      end

      // Hardwired-zero register 0 and the top register of the 16-entry file.
      RegWrite = 1'b1; rd = 4'd0; WriteData = 16'hFFFF; rs = 4'd0; cyc(1'b1);
      RegWrite = 1'b0; cyc(1'b1);
      RegWrite = 1'b1; rd = 4'd15; WriteData = 16'hC0DE; rt = 4'd15; cyc(1'b1);
      RegWrite = 1'b0; cyc(1'b1);

      // Random traffic including occasional ClearReq and reset (mid-sweep restarts included).
      for (int n = 0; n < 400; n++) begin
         rs = 4'($urandom_range(0, 15));
         rt = 4'($urandom_range(0, 15));
         rd = 4'($urandom_range(0, 15));
         WriteData = 16'($urandom);
         RegWrite = 1'($urandom % 2);
         ClearReq = ($urandom % 24) == 0;
         ResetN = ($urandom % 60) != 0;
         cyc(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 8x16 register file: configurable width and depth, two combinational read ports, one synchronous write port.
- Adds a hardware clear sweep after reset or on request, an optional hardwired-zero register 0, and a dropped-write indicator.
- Sits in the decode/writeback path of the 16-bit CPU datapath; it is the drop-in replacement for the fixed register file.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W.
- ZERO_REG0, 0, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- ResetN  input  1  synchronous, active-low reset.
- RS  input  ADDR_W  read port A index.
- RT  input  ADDR_W  read port B index.
- RD  input  ADDR_W  write index.
- WriteData  input  DATA_W  write data.
- RegWrite  input  1  write enable.
- ClearReq  input  1  one-cycle request to re-zero all registers.
- ReadRS  output  DATA_W  contents of Registers[RS].
- ReadRT  output  DATA_W  contents of Registers[RT].
- Ready  output  1  1 = normal operation; 0 = clear sweep in progress.
- WriteDropped  output  1  registered one-cycle pulse: a write was discarded during the sweep.

Behaviour:
- Clock and reset: one clock (Clock); reset is synchronous and active-low (ResetN low at a rising edge resets).
- Reset values: state=CLEAR, ClearIdx=0, Ready=0, WriteDropped=0. Array contents are not reset directly; the sweep zeroes them.
- FSM states: CLEAR and RUN.
- CLEAR: each edge writes 0 to Registers[ClearIdx] and increments ClearIdx.
  - At the edge that writes NUM_REGS-1: go to RUN, set Ready=1, and wrap ClearIdx to 0.
  - Ready therefore rises on the NUM_REGS-th rising edge after ResetN goes high.
- RUN: at each edge, if RegWrite then Registers[RD] <= WriteData. Exception: with ZERO_REG0=1 and RD=0, the write is discarded silently (WriteDropped stays 0).
- ClearReq:
  - Sampled in RUN only. At that edge: go to CLEAR, Ready=0, ClearIdx=0; no register is zeroed at that edge.
  - A RegWrite on the same edge still commits (the write takes effect, then the sweep zeroes it).
  - ClearReq during CLEAR is ignored; the sweep does not restart.
- Writes during CLEAR: RegWrite=1 at an edge in CLEAR is discarded, and WriteDropped=1 for the following cycle only.
- Reads: combinational.
  - In RUN: ReadRS=Registers[RS], ReadRT=Registers[RT].
  - In CLEAR: both read ports output 0.
  - With ZERO_REG0=1, index 0 reads 0 in every state.
- Read-during-write (no bypass): the read returns the old value in the write cycle and the new value after the edge.
- RS=RT: both ports return identical data.
- Reset mid-sweep: restarts the sweep from index 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if RegWrite=1 and RD==RS, ReadRS=WriteData combinationally in the same cycle; the same rule applies to RT/ReadRT. No bypass when the write is discarded (CLEAR state, or ZERO_REG0=1 with RD=0).
- Undefined: no forwarding; read-during-write returns the old value.

Test Plan:
- Reset-to-ready: ResetN low 2 cycles, then high; no writes -> Ready=0 for exactly 8 edges, 1 after the 8th; all 8 registers read 0x0000.
- Basic write/read: write R3=0xBEEF, R5=0x1234 on consecutive edges; next cycle RS=3, RT=5 -> ReadRS=0xBEEF, ReadRT=0x1234; RS=RT=3 -> both 0xBEEF.
- Read-during-write: RegWrite=1, RD=2, WriteData=0xA5A5, R2 previously 0x0001, RS=2 -> ReadRS=0x0001 without the macro, 0xA5A5 with REGFILE_BYPASS_EN; 0xA5A5 after the edge in both builds.
- Clear request: fill R0..R7 with 0x1111..0x8888; pulse ClearReq together with RegWrite R1=0x9999 -> Ready=0 next cycle; reads 0 during the sweep; Ready=1 after 8 further edges; all registers 0x0000.
- Dropped write: during the sweep, RegWrite=1, RD=4, WriteData=0x7777 -> WriteDropped=1 for one cycle; after Ready, R4 reads 0x0000.
- ZERO_REG0=1, ADDR_W=4: write R0=0xFFFF -> R0 reads 0x0000 and WriteDropped stays 0; write R15=0xC0DE -> R15 reads 0xC0DE; Ready rises 16 edges after reset release.
